f4_ram_ctrl: RTL and testbench
==============================

# f4_ram_ctrl

Ping-pong sequencer for the F4 feature-map RAM (16 lanes × 16 bit, 128 × 256-bit dual-port block RAM, 1-cycle read latency). It sits between the S4 pooling stage and the C5 fully-connected stage. The RAM is split into two 64-entry banks: S4 fills one bank with a 25-word frame while C5 reads the other bank one or more times. The block generates all RAM addresses and the write enable, and tracks bank ownership. Write data and read data bypass it and connect straight to the RAM.

## Interface
Parameters:
- FRAME_LEN, 25, words per frame (one word = 16 lanes); legal range 1..64.
- BANK_BASE1, 64, base address of bank 1 (bank 0 base is 0).
- READ_PASSES, 1, full read sweeps of a frame before its bank is released; legal range 1..255.

Ports:
- clk  in  1  single clock; all logic rises on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- s4_valid  in  1  S4 presents a pooled word this cycle.
- s4_ready  out  1  the current write bank is EMPTY, so the word is accepted.
- f4_wr_en  out  1  RAM write enable.
- f4_waddr  out  7  RAM write address.
- c5_req  in  1  level signal; C5 wants a frame.
- f4_raddr  out  7  RAM read address.
- f4_rd_valid  out  1  RAM read data is valid this cycle.
- f4_rd_last  out  1  qualifies the final word of the final pass.
- rd_busy  out  1  read sweep in progress.
- bank_full  out  2  per-bank FULL flags (bit i = bank i).

## Operation
- **State per bank:** one bit, EMPTY=0 or FULL=1. After reset both banks are EMPTY, wbank=0, rbank=0.
- **Write side (no FSM, counter wcnt 0..FRAME_LEN-1):**
  - s4_ready = ~bank_full[wbank].
  - f4_wr_en = s4_valid & s4_ready, combinational.
  - f4_waddr = base(wbank) + wcnt.
  - On each accepted word, wcnt increments.
  - On the accepted word with wcnt = FRAME_LEN-1: wcnt←0, bank_full[wbank]←1, wbank toggles.
- **Read FSM, states IDLE, SWEEP, DRAIN:**
  - IDLE → SWEEP when c5_req & bank_full[rbank]. Clear rcnt and pass.
  - SWEEP: each cycle f4_raddr = base(rbank) + rcnt and rcnt increments. At rcnt = FRAME_LEN-1, rcnt←0 and pass increments. On the last address of pass READ_PASSES-1, go to DRAIN.
  - DRAIN (1 cycle): bank_full[rbank]←0, rbank toggles, then → IDLE.
  - c5_req deasserting mid-sweep has no effect. A started sweep always completes.
- **Idle outputs:** in IDLE, f4_raddr holds its last value and no read is issued.
- **Arithmetic:** rcnt and wcnt are 6 bit. pass is 8 bit. Address = base + counter, 7 bit, with no wrap past the bank.
- **Simultaneous events:**
  - A write completing on one bank and DRAIN releasing the other bank in the same cycle both take effect.
  - A write can never target rbank while it is FULL, because s4_ready is 0.
- **Reset mid-operation:** counters, FSM, flags and bank pointers return to their reset values immediately. A partially written frame is discarded.

## Timing
- Reset values:
  - s4_ready = 1.
  - f4_wr_en = 0 (because s4_valid is expected to be 0 under reset).
  - f4_waddr = 0, f4_raddr = 0.
  - f4_rd_valid = 0, f4_rd_last = 0.
  - rd_busy = 0, bank_full = 2'b00.
- Write latency: 0. The address and enable are issued in the same cycle the handshake is accepted.
- Read pipeline:
  - f4_raddr is registered and valid in the first SWEEP cycle, which is one cycle after the IDLE→SWEEP decision.
  - f4_rd_valid and f4_rd_last are registered one cycle behind f4_raddr, so they align with the RAM's doutb.
  - A sweep presents FRAME_LEN × READ_PASSES back-to-back valid words.
- rd_busy = 1 in SWEEP and DRAIN.
- bank_full for the read bank clears at the end of the DRAIN cycle. The earliest rewrite of that bank is the next cycle.
- Back-to-back frames: with c5_req held high and the other bank FULL, SWEEP restarts 1 cycle after DRAIN (one IDLE cycle).

## Structure
- Shared package `lenet_pkg` holds:
  - F4_FRAME_LEN = 25.
  - F4_ADDR_W = 7.
  - F4_BANK_BASE1 = 64.
  - The read-FSM state enum {RD_IDLE, RD_SWEEP, RD_DRAIN}.
- Single module; no sub-module is warranted.
- f4_ram_ctrl drives f4_ram's f4_wr_en, f4_waddr and f4_raddr ports directly.

## Test plan
- **Reset:** assert rst mid-write at wcnt=10. Required: all outputs return to their reset values asynchronously. The next accepted word goes to address 0.
- **Single frame fill:** 25 consecutive s4_valid. Required:
  - f4_waddr runs 0..24.
  - bank_full becomes 2'b01 after word 25.
  - The next word goes to address 64.
- **Backpressure:** fill both banks with c5_req = 0. Required: s4_ready = 0 and f4_wr_en = 0 while s4_valid is held.
- **Single-pass read:** c5_req = 1 with bank 0 FULL. Required:
  - f4_raddr runs 0..24.
  - f4_rd_valid is high for 25 cycles, lagging f4_raddr by 1 cycle.
  - f4_rd_last is high on the 25th.
  - bank_full[0] clears after DRAIN.
- **Multi-pass read:** READ_PASSES = 3 with bank 1 FULL. Required:
  - Addresses sweep 64..88 three times.
  - Exactly 75 valid words are presented.
  - f4_rd_last is high once only.
- **Concurrent ping-pong:** S4 streams continuously while C5 reads continuously. Required:
  - Bank 1 fills while bank 0 is read.
  - A write completing in the same cycle as DRAIN updates both flags correctly.
  - No frame is lost or overwritten across 4 frames.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet constants and types used by the F4 feature-map RAM sequencer.
package lenet_pkg;

  localparam int F4_FRAME_LEN  = 25;
  localparam int F4_ADDR_W     = 7;
  localparam int F4_BANK_BASE1 = 64;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_SWEEP,
    RD_DRAIN
  } f4_rd_state_t;

endpackage

// File: rtl/f4_ram_ctrl_if.sv
// Handshake and RAM-address bundle between S4, C5, the F4 RAM and its sequencer.
interface f4_ram_ctrl_if;
  import lenet_pkg::*;

  logic                 s4_valid;
  logic                 s4_ready;
  logic                 f4_wr_en;
  logic [F4_ADDR_W-1:0] f4_waddr;
  logic                 c5_req;
  logic [F4_ADDR_W-1:0] f4_raddr;
  logic                 f4_rd_valid;
  logic                 f4_rd_last;
  logic                 rd_busy;
  logic [1:0]           bank_full;

  // Producer/consumer side: S4 and C5 drive the requests and watch the status.
  modport master (
    output s4_valid, c5_req,
    input  s4_ready, f4_wr_en, f4_waddr, f4_raddr, f4_rd_valid, f4_rd_last,
           rd_busy, bank_full
  );

  // Sequencer side.
  modport slave (
    input  s4_valid, c5_req,
    output s4_ready, f4_wr_en, f4_waddr, f4_raddr, f4_rd_valid, f4_rd_last,
           rd_busy, bank_full
  );

endinterface

// File: rtl/f4_ram_ctrl.sv
// Ping-pong address sequencer for the F4 feature-map RAM. S4 fills one
// 64-entry bank while C5 sweeps the other one READ_PASSES times.
module f4_ram_ctrl
  import lenet_pkg::*;
#(
  parameter int FRAME_LEN   = F4_FRAME_LEN,
  parameter int BANK_BASE1  = F4_BANK_BASE1,
  parameter int READ_PASSES = 1
) (
  input  logic         clk,
  input  logic         rst,
  f4_ram_ctrl_if.slave bus
);

  localparam logic [F4_ADDR_W-1:0] BASE1     = F4_ADDR_W'(BANK_BASE1);
  localparam logic [5:0]           LAST_IDX  = 6'(FRAME_LEN - 1);
  localparam logic [7:0]           LAST_PASS = 8'(READ_PASSES - 1);

  f4_rd_state_t         state, state_nxt;
  logic [1:0]           bank_full, set_mask, clr_mask;
  logic                 wbank, rbank;
  logic [5:0]           wcnt, rcnt, rcnt_nxt;
  logic [7:0]           pass, pass_nxt;
  logic                 wr_accept, wr_done, sweep_last;
  logic [F4_ADDR_W-1:0] raddr;
  logic                 rd_valid, rd_last;

  function automatic logic [F4_ADDR_W-1:0] base_of(input logic bank);
    return bank ? BASE1 : '0;
  endfunction

  assign wr_accept = bus.s4_valid & ~bank_full[wbank];
  assign wr_done   = wr_accept & (wcnt == LAST_IDX);

  assign bus.s4_ready    = ~bank_full[wbank];
  assign bus.f4_wr_en    = wr_accept;
  assign bus.f4_waddr    = base_of(wbank) + {1'b0, wcnt};
  assign bus.f4_raddr    = raddr;
  assign bus.f4_rd_valid = rd_valid;
  assign bus.f4_rd_last  = rd_last;
  assign bus.rd_busy     = (state != RD_IDLE);
  assign bus.bank_full   = bank_full;

  // A completed write sets its bank's flag; DRAIN clears the read bank's flag.
  always_comb begin
    set_mask = 2'b00;
    clr_mask = 2'b00;
    if (wr_done)
      set_mask[wbank] = 1'b1;
    if (state == RD_DRAIN)
      clr_mask[rbank] = 1'b1;
  end

  // Write word counter and write-bank pointer, toggling at the end of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (wr_accept) begin
      if (wr_done) begin
        wcnt  <= '0;
        wbank <= ~wbank;
      end else begin
        wcnt <= wcnt + 6'd1;
      end
    end
  end

  // Bank ownership flags and read-bank pointer; both banks may change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= 2'b00;
      rbank     <= 1'b0;
    end else begin
      bank_full <= (bank_full | set_mask) & ~clr_mask;
      if (state == RD_DRAIN)
        rbank <= ~rbank;
    end
  end

  // Read FSM next state and sweep counters.
  always_comb begin
    state_nxt  = state;
    rcnt_nxt   = rcnt;
    pass_nxt   = pass;
    sweep_last = 1'b0;
    case (state)
      RD_IDLE: begin
        if (bus.c5_req & bank_full[rbank]) begin
          state_nxt = RD_SWEEP;
          rcnt_nxt  = '0;
          pass_nxt  = '0;
        end
      end
      RD_SWEEP: begin
        if (rcnt == LAST_IDX) begin
          rcnt_nxt = '0;
          pass_nxt = pass + 8'd1;
          if (pass == LAST_PASS) begin
            state_nxt  = RD_DRAIN;
            sweep_last = 1'b1;
          end
        end else begin
          rcnt_nxt = rcnt + 6'd1;
        end
      end
      RD_DRAIN: state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RD_IDLE;
    else
      state <= state_nxt;
  end

  // Registered read address, with valid/last delayed one cycle to line up with RAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt     <= '0;
      pass     <= '0;
      raddr    <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rcnt     <= rcnt_nxt;
      pass     <= pass_nxt;
      rd_valid <= (state == RD_SWEEP);
      rd_last  <= sweep_last;
      if (state_nxt == RD_SWEEP)
        raddr <= base_of(rbank) + {1'b0, rcnt_nxt};
    end
  end

endmodule

// File: tb/tb_f4_ram_ctrl.sv
// Directed bench for f4_ram_ctrl: one single-pass instance with a RAM model
// tracking data end to end, and one three-pass instance for the multi-pass read.
module tb_f4_ram_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  int   mem [128];
  int   wtag, rtag, prev_data;
  bit   mon_en;

  f4_ram_ctrl_if bus1 ();
  f4_ram_ctrl_if bus3 ();

  f4_ram_ctrl #(.FRAME_LEN(25), .BANK_BASE1(64), .READ_PASSES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  f4_ram_ctrl #(.FRAME_LEN(25), .BANK_BASE1(64), .READ_PASSES(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit later; the RAM
  // model writes accepted words and checks read data one cycle after its address.
  task automatic applyStimulus(input logic v1, input logic r1,
                               input logic v3, input logic r3);
    @(negedge clk);
    bus1.s4_valid = v1;
    bus1.c5_req   = r1;
    bus3.s4_valid = v3;
    bus3.c5_req   = r3;
    #1;
    if (mon_en) begin
      if (bus1.f4_rd_valid === 1'b1) begin
        checkOutput("rd_data", prev_data, rtag);
        rtag++;
      end
      prev_data = mem[bus1.f4_raddr];
      if (bus1.f4_wr_en === 1'b1) begin
        mem[bus1.f4_waddr] = wtag;
        wtag++;
      end
    end
  endtask

  initial begin
    int v0, v1, l1, lastj;
    bit seen;

    rst = 1'b1;
    mon_en = 1'b0;
    bus1.s4_valid = 1'b0; bus1.c5_req = 1'b0;
    bus3.s4_valid = 1'b0; bus3.c5_req = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_s4_ready",  bus1.s4_ready, 1);
    checkOutput("rst_wr_en",     bus1.f4_wr_en, 0);
    checkOutput("rst_waddr",     bus1.f4_waddr, 0);
    checkOutput("rst_raddr",     bus1.f4_raddr, 0);
    checkOutput("rst_rd_valid",  bus1.f4_rd_valid, 0);
    checkOutput("rst_rd_last",   bus1.f4_rd_last, 0);
    checkOutput("rst_rd_busy",   bus1.rd_busy, 0);
    checkOutput("rst_bank_full", bus1.bank_full, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a frame at wcnt=10.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_waddr", bus1.f4_waddr, i);
    end
    @(negedge clk);
    bus1.s4_valid = 1'b1;
    #1;
    checkOutput("pre_rst_wcnt10", bus1.f4_waddr, 10);
    #2;
    rst = 1'b1;
    bus1.s4_valid = 1'b0;
    #1;
    checkOutput("async_rst_waddr", bus1.f4_waddr, 0);
    checkOutput("async_rst_wr_en", bus1.f4_wr_en, 0);
    checkOutput("async_rst_ready", bus1.s4_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Single frame fill into bank 0, then bank 1.
    foreach (mem[k]) mem[k] = -1;
    wtag = 0; rtag = 0; prev_data = -1;
    mon_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("fill0_waddr", bus1.f4_waddr, i);
      checkOutput("fill0_wr_en", bus1.f4_wr_en, 1);
    end
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 0) checkOutput("fill0_bank_full", bus1.bank_full, 2'b01);
      checkOutput("fill1_waddr", bus1.f4_waddr, 64 + i);
    end

    // Backpressure with both banks full.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_bank_full", bus1.bank_full, 2'b11);
      checkOutput("bp_s4_ready",  bus1.s4_ready, 0);
      checkOutput("bp_wr_en",     bus1.f4_wr_en, 0);
    end

    // Single-pass read of bank 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rd0_idle_busy", bus1.rd_busy, 0);
    for (int k = 0; k < 25; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rd0_raddr", bus1.f4_raddr, k);
      checkOutput("rd0_busy",  bus1.rd_busy, 1);
      checkOutput("rd0_valid", bus1.f4_rd_valid, (k != 0));
      checkOutput("rd0_last",  bus1.f4_rd_last, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rd0_drain_busy",  bus1.rd_busy, 1);
    checkOutput("rd0_drain_valid", bus1.f4_rd_valid, 1);
    checkOutput("rd0_drain_last",  bus1.f4_rd_last, 1);
    checkOutput("rd0_drain_full",  bus1.bank_full, 2'b11);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rd0_after_full",  bus1.bank_full, 2'b10);
    checkOutput("rd0_after_busy",  bus1.rd_busy, 0);
    checkOutput("rd0_after_valid", bus1.f4_rd_valid, 0);

    // Back-to-back sweep of bank 1 after one idle cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("b2b_raddr", bus1.f4_raddr, 64);
    checkOutput("b2b_busy",  bus1.rd_busy, 1);

    // Concurrent ping-pong: writes timed so frame completion meets DRAIN.
    for (int t = 2; t < 400; t++) begin
      applyStimulus((wtag < 125), 1'b1, 1'b0, 1'b0);
      if (t == 26) begin
        checkOutput("pp_drain_busy",  bus1.rd_busy, 1);
        checkOutput("pp_drain_wr_en", bus1.f4_wr_en, 1);
        checkOutput("pp_drain_waddr", bus1.f4_waddr, 24);
        checkOutput("pp_drain_full",  bus1.bank_full, 2'b10);
      end
      if (t == 27) begin
        checkOutput("pp_swap_full",  bus1.bank_full, 2'b01);
        checkOutput("pp_swap_waddr", bus1.f4_waddr, 64);
      end
      if (rtag == 125) break;
    end
    checkOutput("pp_words_read",    rtag, 125);
    checkOutput("pp_words_written", wtag, 125);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pp_end_full", bus1.bank_full, 2'b00);
    checkOutput("pp_end_busy", bus1.rd_busy, 0);
    mon_en = 1'b0;

    // Three-pass instance: fill both banks.
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("mp_fill_waddr", bus3.f4_waddr, (i < 25) ? i : 64 + i - 25);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mp_fill_full", bus3.bank_full, 2'b11);

    // Read bank 0 three times, bounded wait for its release.
    v0 = 0;
    seen = 1'b0;
    for (int j = 0; j < 200; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (bus3.f4_rd_valid === 1'b1) v0++;
      if (bus3.bank_full === 2'b10) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("mp_bank0_release", seen, 1);
    checkOutput("mp_bank0_words",   v0, 75);

    // Bank 1 sweeps 64..88 three times.
    v1 = 0; l1 = 0; lastj = -1;
    for (int j = 0; j < 78; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if (j < 75) checkOutput("mp_raddr", bus3.f4_raddr, 64 + (j % 25));
      if (bus3.f4_rd_valid === 1'b1) v1++;
      if (bus3.f4_rd_last === 1'b1) begin
        l1++;
        lastj = j;
      end
    end
    checkOutput("mp_bank1_words", v1, 75);
    checkOutput("mp_last_count",  l1, 1);
    checkOutput("mp_last_pos",    lastj, 75);
    checkOutput("mp_end_full",    bus3.bank_full, 2'b00);
    checkOutput("mp_end_busy",    bus3.rd_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
